mem_wb_stage: RTL
=================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL provide parameter MEM_TIMEOUT, default 15, max cycles spent waiting for load data before error.
REQ-002 SHALL provide parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock shared with RegisterFile.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  upstream MEM stage presents an instruction.
REQ-007 in_ready  output  1  stage accepts an instruction this cycle.
REQ-008 in_wr_en  input  1  instruction writes a register.
REQ-009 in_is_load  input  1  result comes from memory, not the ALU.
REQ-010 in_halt  input  1  instruction is HLT.
REQ-011 in_dst_reg  input  4  destination register.
REQ-012 in_alu_result  input  16  ALU result.
REQ-013 mem_data  input  16  load data.
REQ-014 mem_data_valid  input  1  mem_data valid this cycle.
REQ-015 WriteReg  output  1  RegisterFile write enable.
REQ-016 DstReg  output  4  RegisterFile write address.
REQ-017 DstData  output  16  RegisterFile write data.
REQ-018 halted  output  1  sticky, set once HLT commits.
REQ-019 mem_err  output  1  sticky load-timeout flag.
REQ-020 retired  output  CNT_W  committed-instruction count.

Function
REQ-021 SHALL implement a state machine with states IDLE, WAIT_MEM, COMMIT and HALT.
REQ-022 In IDLE, a handshake (in_valid && in_ready) with in_is_load=1 SHALL go to WAIT_MEM; any other handshake SHALL go to COMMIT and latch in_alu_result.
REQ-023 in_ready SHALL be 1 in IDLE and COMMIT, and 0 in WAIT_MEM and HALT.
REQ-024 In WAIT_MEM, mem_data_valid=1 SHALL latch mem_data and go to COMMIT on the next edge.
REQ-025 mem_data_valid outside WAIT_MEM SHALL be ignored.
REQ-026 In WAIT_MEM, a wait counter SHALL increment each cycle.
REQ-027 If the wait counter reaches MEM_TIMEOUT without mem_data_valid, the stage SHALL set mem_err, latch 16'h0000 and go to COMMIT.
REQ-028 If mem_data_valid arrives in the same cycle as the timeout, data SHALL win and mem_err SHALL stay 0.
REQ-029 COMMIT SHALL last exactly one cycle.
REQ-030 In COMMIT, WriteReg SHALL be latched wr_en && (latched dst != 0), with DstReg and DstData driven from latched values; R0 writes SHALL be suppressed.
REQ-031 Outside COMMIT, WriteReg SHALL be 0.
REQ-032 DstReg and DstData SHALL hold their last values outside COMMIT.
REQ-033 An ALU instruction SHALL reach WriteReg exactly 1 cycle after its handshake.
REQ-034 A load SHALL reach WriteReg 1 cycle after the cycle mem_data_valid is sampled.
REQ-035 A handshake during COMMIT SHALL be accepted (back-to-back throughput of 1 per cycle), with the next state chosen per REQ-022.
REQ-036 Commit of a latched halt SHALL set halted and go to HALT instead of IDLE.
REQ-037 HALT SHALL be exited only by reset.
REQ-038 The halt commit SHALL still write a register if its wr_en is set.
REQ-039 retired SHALL increment by 1 per COMMIT cycle, including R0-suppressed and halt commits.
REQ-040 retired SHALL saturate at all-ones.

Reset
REQ-041 rst_n low SHALL immediately force state IDLE, WriteReg=0, DstReg=0, DstData=0, halted=0, mem_err=0, retired=0, wait counter=0, and all latches 0.
REQ-042 A reset asserted mid-WAIT_MEM or mid-COMMIT SHALL abandon the instruction with no register write.
REQ-043 in_ready SHALL be 1 on the first cycle after rst_n deasserts.

Structure
REQ-044 Package wb_pkg SHALL hold the state enum (IDLE, WAIT_MEM, COMMIT, HALT) and the constant ZERO_REG = 4'd0.
REQ-045 Sub-module mem_wait_timer SHALL implement the wait counter with clear and timeout outputs.
REQ-046 Everything else SHALL live in mem_wb_stage.

Verification
REQ-047 ALU op (dst=3, alu=16'h00AB) handshake at cycle N -> WriteReg=1, DstReg=3, DstData=16'h00AB at cycle N+1; a RegisterFile read of R3 returns 16'h00AB (bypass same cycle).
REQ-048 Load (dst=5), mem_data_valid with 16'h1234 after 3 wait cycles -> in_ready=0 for those 3 cycles, commit of 16'h1234 one cycle later, retired=1.
REQ-049 Load with mem_data_valid never asserted -> after 15 wait cycles mem_err=1, commit of DstData=16'h0000, stage returns to IDLE.
REQ-050 Sixteen back-to-back ALU ops (dst=i, data=i) -> one write per cycle and retired=16; the dst=0 op gives WriteReg=0.
REQ-051 HLT with wr_en=0 followed by another in_valid -> halted=1, in_ready stuck at 0, no further writes, retired frozen until rst_n pulse.
REQ-052 rst_n pulsed low during WAIT_MEM -> no write and all outputs zero; a subsequent ALU op commits normally.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the memory/write-back stage.
// Holds the stage state encoding, the zero-register constant and the commit bundle.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MEM,
        COMMIT,
        HALT
    } wb_state_e;

    localparam logic [3:0] ZERO_REG = 4'd0;

    // One register-file write request as seen at the edge that enters COMMIT.
    typedef struct packed {
        logic        wr_en;
        logic [3:0]  dst;
        logic [15:0] data;
    } wb_commit_t;

    function automatic logic writes_reg(input logic wr_en, input logic [3:0] dst);
        return wr_en && (dst != ZERO_REG);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting for load data and flags the final allowed cycle.
// timeout is high during the TIMEOUT-th consecutive cycle of run.
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic timeout
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] count;

    assign timeout = run && (count == W'(TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && !timeout) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-wait / write-back stage: waits for load data (with timeout), then
// commits one register-file write per instruction and tracks halt and retire count.
module mem_wb_stage
    import wb_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_wr_en,
    input  logic             in_is_load,
    input  logic             in_halt,
    input  logic [3:0]       in_dst_reg,
    input  logic [15:0]      in_alu_result,
    input  logic [15:0]      mem_data,
    input  logic             mem_data_valid,
    output logic             WriteReg,
    output logic [3:0]       DstReg,
    output logic [15:0]      DstData,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] retired
);

    wb_state_e  state;
    logic       lat_wr_en;
    logic       lat_halt;
    logic [3:0] lat_dst;

    logic       handshake;
    logic       halt_commit;
    logic       wait_timeout;
    logic       commit_go;
    logic       commit_timeout;
    wb_commit_t commit;

    assign in_ready    = (state == IDLE) || (state == COMMIT);
    assign handshake   = in_valid && in_ready;
    // A halt commit ends the stream; anything offered alongside it is dropped.
    assign halt_commit = (state == COMMIT) && lat_halt;

    mem_wait_timer #(
        .TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state != WAIT_MEM),
        .run     (state == WAIT_MEM),
        .timeout (wait_timeout)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        commit_go      = 1'b0;
        commit_timeout = 1'b0;
        commit         = '{wr_en: lat_wr_en, dst: lat_dst, data: mem_data};
        case (state)
            IDLE, COMMIT: begin
                if (handshake && !in_is_load && !halt_commit) begin
                    commit_go = 1'b1;
                    commit    = '{wr_en: in_wr_en, dst: in_dst_reg, data: in_alu_result};
                end
            end
            WAIT_MEM: begin
                if (mem_data_valid) begin
                    commit_go = 1'b1;
                end else if (wait_timeout) begin
                    commit_go      = 1'b1;
                    commit_timeout = 1'b1;
                    commit.data    = 16'h0000;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat_wr_en <= 1'b0;
            lat_halt  <= 1'b0;
            lat_dst   <= ZERO_REG;
            WriteReg  <= 1'b0;
            DstReg    <= ZERO_REG;
            DstData   <= 16'h0000;
            halted    <= 1'b0;
            mem_err   <= 1'b0;
            retired   <= '0;
        end else begin
            WriteReg <= 1'b0;
            case (state)
                IDLE, COMMIT: begin
                    if (halt_commit) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (handshake) begin
                        lat_wr_en <= in_wr_en;
                        lat_dst   <= in_dst_reg;
                        lat_halt  <= in_halt;
                        state     <= in_is_load ? WAIT_MEM : COMMIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT_MEM: begin
                    if (commit_go) begin
                        state <= COMMIT;
                    end
                    if (commit_timeout) begin
                        mem_err <= 1'b1;
                    end
                end
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase

            // Outputs are loaded on entry to COMMIT so they are valid for that whole cycle.
            if (commit_go) begin
                WriteReg <= writes_reg(commit.wr_en, commit.dst);
                DstReg   <= commit.dst;
                DstData  <= commit.data;
                if (retired != {CNT_W{1'b1}}) begin
                    retired <= retired + 1'b1;
                end
            end
        end
    end

endmodule
